digit_scan_sequencer: RTL and testbench



---
 rtl/digit_scan_sequencer_if.sv | 25 ++
 rtl/digit_scan_sequencer.sv | 139 +++++++++++++
 tb/tb_digit_scan_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/digit_scan_sequencer_if.sv
// Bundle between a scan master (drives run/mask) and the digit scan
// sequencer (drives the decoder-facing outputs).
//
// Signalling: there is no valid/ready handshake on this bundle. run and mask
// are level inputs. The sequencer samples them on every rising clk edge
// (mask only in IDLE and at slot boundaries). sel/En are registered levels.
// slotStart/frameDone are single-cycle registered pulses.
interface digit_scan_sequencer_if;
  logic       run;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       En;
  logic       slotStart;
  logic       frameDone;

  modport master (
    output run, mask,
    input  sel, En, slotStart, frameDone
  );

  modport slave (
    input  run, mask,
    output sel, En, slotStart, frameDone
  );
endinterface

// File: rtl/digit_scan_sequencer.sv
// Time-multiplexed digit scan controller feeding a 2-to-4 decoder with enable.
// Each slot is DIV cycles long. En is held low for the first BLANK cycles of
// each slot to suppress ghosting. Digits whose mask bit is clear are skipped.
// The FSM state is exported on dbg_state_o (0=IDLE, 1=BLANKING, 2=DRIVE).
module digit_scan_sequencer #(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  digit_scan_sequencer_if.slave bus,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLANK_LAST_I = (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LAST_I);
  localparam logic          START_EN   = (BLANK == 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BLANKING = 2'd1,
    DRIVE    = 2'd2
  } state_t;

  // With no blanking interval a slot begins directly in DRIVE.
  localparam state_t FIRST_STATE = (BLANK == 0) ? DRIVE : BLANKING;

  state_t        state_q;
  logic [1:0]    sel_q;
  logic          en_q;
  logic          slot_start_q;
  logic          frame_done_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]    first_sel_d;
  logic [1:0]    next_sel_d;

  // Lowest set bit of m; only meaningful when m != 0.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next set bit searching upward from cur+1, wrapping, ending at cur itself.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Digit selection candidates for a scan start and for a slot boundary.
  assign first_sel_d = lowest_set(bus.mask);
  assign next_sel_d  = next_set(bus.mask, sel_q);

  // Scan FSM: all outputs registered; run=0 forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      en_q         <= 1'b0;
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (!bus.run) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            en_q <= 1'b0;
            if (bus.mask != 4'd0) begin
              sel_q        <= first_sel_d;
              cnt_q        <= '0;
              slot_start_q <= 1'b1;
              state_q      <= FIRST_STATE;
              en_q         <= START_EN;
            end
          end
          BLANKING: begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == BLANK_LAST) begin
              state_q <= DRIVE;
              en_q    <= 1'b1;
            end
          end
          DRIVE: begin
            if (cnt_q == DIV_LAST) begin
              cnt_q <= '0;
              if (bus.mask == 4'd0) begin
                state_q <= IDLE;
                en_q    <= 1'b0;
              end else begin
                sel_q        <= next_sel_d;
                slot_start_q <= 1'b1;
                frame_done_q <= (next_sel_d <= sel_q);
                state_q      <= FIRST_STATE;
                en_q         <= START_EN;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.En        = en_q;
  assign bus.slotStart = slot_start_q;
  assign bus.frameDone = frame_done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: a cycle table for DIV=8/BLANK=2 and a
// hand-written sequence for DIV=2/BLANK=0.
module tb_digit_scan_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  typedef struct {
    logic       rst;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en;
    logic       ss;
    logic       fd;
    logic [1:0] st;
  } vec_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  digit_scan_sequencer_if bus_a ();
  digit_scan_sequencer_if bus_b ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  digit_scan_sequencer #(.DIV(8), .BLANK(2)) dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .bus         (bus_a.slave),
    .dbg_state_o (dbg_a)
  );

  digit_scan_sequencer #(.DIV(2), .BLANK(0)) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .bus         (bus_b.slave),
    .dbg_state_o (dbg_b)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic run, input logic [3:0] mask,
                     input logic [1:0] sel, input logic en, input logic ss,
                     input logic fd, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.run = run; v.mask = mask; v.sel = sel;
    v.en = en; v.ss = ss; v.fd = fd; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int slot;
    int pos;
    logic [3:0] m;
    logic [1:0] s;

    bus_a.run = 1'b0; bus_a.mask = 4'd0;
    bus_b.run = 1'b0; bus_b.mask = 4'd0;

    // Reset held three cycles with run=1, mask=1111.
    for (int i = 0; i < 3; i++) add(1, 1, 4'hF, 0, 0, 0, 0, S_IDLE);

    // Full scan, then mask 1111->0001 mid digit-1 DRIVE, then mask=0 mid slot.
    for (int k = 0; k < 64; k++) begin
      slot = k / 8;
      pos  = k % 8;
      m = (k <= 43) ? 4'hF : ((k <= 57) ? 4'h1 : 4'h0);
      s = (k < 48) ? 2'(slot % 4) : 2'd0;
      add(0, 1, m, s, pos >= 2, pos == 0, (pos == 0) && (k > 0) && (s == 2'd0),
          (pos < 2) ? S_BLANK : S_DRIVE);
    end
    // Boundary with mask=0: IDLE, no pulses, sel held.
    for (int k = 0; k < 3; k++) add(0, 1, 4'h0, 0, 0, 0, 0, S_IDLE);

    // Skip: mask=1010 alternates 1,3; stop at counter=4 of a digit-3 DRIVE slot.
    for (int j = 0; j <= 44; j++) begin
      slot = j / 8;
      pos  = j % 8;
      s = (slot % 2 == 1) ? 2'd3 : 2'd1;
      add(0, 1, 4'hA, s, pos >= 2, pos == 0, (pos == 0) && (j > 0) && (s == 2'd1),
          (pos < 2) ? S_BLANK : S_DRIVE);
    end
    for (int k = 0; k < 2; k++) add(0, 0, 4'hA, 3, 0, 0, 0, S_IDLE);

    // Restart from lowest set digit with a cleared counter.
    for (int j = 0; j < 10; j++) begin
      slot = j / 8;
      pos  = j % 8;
      s = (slot % 2 == 1) ? 2'd3 : 2'd1;
      add(0, 1, 4'hA, s, pos >= 2, pos == 0, 1'b0, (pos < 2) ? S_BLANK : S_DRIVE);
    end
    // Reset during BLANKING (j=9 is slot 1, pos 1).
    add(1, 1, 4'hA, 0, 0, 0, 0, S_IDLE);

    // Single digit mask=0100: sel stays 2, frameDone every slot.
    for (int k = 0; k < 18; k++) begin
      pos = k % 8;
      add(0, 1, 4'h4, 2, pos >= 2, pos == 0, (pos == 0) && (k > 0),
          (pos < 2) ? S_BLANK : S_DRIVE);
    end

    // Apply table.
    #1;
    foreach (vecs[i]) begin
      rst_a      = vecs[i].rst;
      bus_a.run  = vecs[i].run;
      bus_a.mask = vecs[i].mask;
      tick();
      chk("sel",       i, int'(bus_a.sel),       int'(vecs[i].sel));
      chk("En",        i, int'(bus_a.En),        int'(vecs[i].en));
      chk("slotStart", i, int'(bus_a.slotStart), int'(vecs[i].ss));
      chk("frameDone", i, int'(bus_a.frameDone), int'(vecs[i].fd));
      chk("state",     i, int'(dbg_a),           int'(vecs[i].st));
    end

    // BLANK=0, DIV=2: En stays high, sel steps every 2 cycles.
    bus_a.run = 1'b0;
    rst_b = 1'b1;
    bus_b.run = 1'b1;
    bus_b.mask = 4'hF;
    tick();
    chk("b_reset_En",  -1, int'(bus_b.En),  0);
    chk("b_reset_sel", -1, int'(bus_b.sel), 0);
    rst_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("b_En",        k, int'(bus_b.En),        1);
      chk("b_sel",       k, int'(bus_b.sel),       (k / 2) % 4);
      chk("b_slotStart", k, int'(bus_b.slotStart), int'(k % 2 == 0));
      chk("b_frameDone", k, int'(bus_b.frameDone), int'((k % 2 == 0) && (k > 0) && ((k / 2) % 4 == 0)));
      chk("b_state",     k, int'(dbg_b),           int'(S_DRIVE));
    end
    // Stop latency: En low one cycle after run=0 is sampled.
    bus_b.run = 1'b0;
    tick();
    chk("b_stop_En",    -1, int'(bus_b.En), 0);
    chk("b_stop_state", -1, int'(dbg_b),    int'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
